// File: rtl/intc_pkg.sv
// Shared types and constants for the interrupt controller.
// Holds the controller state encoding and the CPU acknowledge qualifier values.
package intc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SVC     = 2'd2,
        NMI_SVC = 2'd3
    } intc_state_t;

    localparam logic ACK_INT = 1'b1;
    localparam logic ACK_NMI = 1'b0;

endpackage

// File: rtl/intc_prio_enc.sv
// Combinational priority encoder: the lowest set index of 'eligible' wins.
module intc_prio_enc #(
    parameter int NUM_IRQ = 8,
    parameter int ID_W    = $clog2(NUM_IRQ)
) (
    input  logic [NUM_IRQ-1:0] eligible,
    output logic               valid,
    output logic [ID_W-1:0]    id
);

    always_comb begin
        valid = 1'b0;
        id    = '0;
        // Scan downward so the final assignment holds the lowest set index.
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                valid = 1'b1;
                id    = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Latches, masks and prioritises peripheral interrupts for the CPU controller,
// tracking one level of maskable service plus NMI preemption.
module interrupt_controller
    import intc_pkg::*;
#(
    parameter int NUM_IRQ = 8,
    parameter int ID_W    = $clog2(NUM_IRQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               nmi_src,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_wdata,
    input  logic               ack,
    input  logic               ack_int,
    input  logic               eoi,
    output logic               INT,
    output logic               NMI,
    output logic               INTD,
    output logic [ID_W-1:0]    vector,
    output logic [NUM_IRQ-1:0] pending
);

    intc_state_t        state_q, state_d;
    intc_state_t        saved_q, saved_d;
    logic [NUM_IRQ-1:0] irq_q;
    logic               nmi_q;
    logic               nmi_pend;
    logic [NUM_IRQ-1:0] mask_q;

    logic [NUM_IRQ-1:0] eligible;
    logic               enc_valid;
    logic [ID_W-1:0]    enc_id;
    logic [ID_W-1:0]    vector_d;
    logic [NUM_IRQ-1:0] clr_onehot;
    logic [NUM_IRQ-1:0] pending_d;
    logic               nmi_pend_d;
    logic               take_nmi;

    assign eligible = pending & ~mask_q;

    intc_prio_enc #(
        .NUM_IRQ (NUM_IRQ),
        .ID_W    (ID_W)
    ) u_prio_enc (
        .eligible (eligible),
        .valid    (enc_valid),
        .id       (enc_id)
    );

    always_comb begin
        state_d    = state_q;
        saved_d    = saved_q;
        vector_d   = vector;
        clr_onehot = '0;
        // NMI preempts everything except an NMI already in service.
        take_nmi   = ack && (ack_int == ACK_NMI) && nmi_pend && (state_q != NMI_SVC);

        if (take_nmi) begin
            state_d = NMI_SVC;
            saved_d = (state_q == SVC) ? SVC : IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enc_valid) begin
                        state_d  = REQ;
                        vector_d = enc_id;
                    end
                end
                REQ: begin
                    if (ack && (ack_int == ACK_INT)) begin
                        state_d            = SVC;
                        clr_onehot[vector] = 1'b1;
                    end else if (mask_q[vector]) begin
                        state_d = IDLE;
                    end
                end
                SVC: begin
                    if (eoi) state_d = IDLE;
                end
                NMI_SVC: begin
                    if (eoi) state_d = saved_q;
                end
                default: state_d = IDLE;
            endcase
        end

        // A new edge on the line being acknowledged survives the clear.
        pending_d  = (irq & ~irq_q) | (pending & ~clr_onehot);
        nmi_pend_d = (nmi_src & ~nmi_q) | (nmi_pend & ~take_nmi);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            saved_q  <= IDLE;
            irq_q    <= '0;
            nmi_q    <= 1'b0;
            pending  <= '0;
            nmi_pend <= 1'b0;
            mask_q   <= '1;
            vector   <= '0;
            INT      <= 1'b0;
            INTD     <= 1'b0;
        end else begin
            state_q  <= state_d;
            saved_q  <= saved_d;
            irq_q    <= irq;
            nmi_q    <= nmi_src;
            pending  <= pending_d;
            nmi_pend <= nmi_pend_d;
            if (mask_we) mask_q <= mask_wdata;
            vector   <= vector_d;
            INT      <= (state_d == REQ);
            INTD     <= (state_d == SVC) || ((state_d == NMI_SVC) && (saved_d == SVC));
        end
    end

    assign NMI = nmi_pend;

endmodule

// File: tb/tb_interrupt_controller.sv
// Scoreboard bench for interrupt_controller: directed scenarios then random traffic,
// each edge checked against a flag-based behavioural model.
module tb_interrupt_controller;

    localparam int N  = 8;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  irq = '0;
    logic          nmi_src = 1'b0;
    logic          mask_we = 1'b0;
    logic [N-1:0]  mask_wdata = '0;
    logic          ack = 1'b0;
    logic          ack_int = 1'b0;
    logic          eoi = 1'b0;
    logic          INT, NMI, INTD;
    logic [IW-1:0] vector;
    logic [N-1:0]  pending;

    interrupt_controller #(.NUM_IRQ(N), .ID_W(IW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .irq        (irq),
        .nmi_src    (nmi_src),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .ack        (ack),
        .ack_int    (ack_int),
        .eoi        (eoi),
        .INT        (INT),
        .NMI        (NMI),
        .INTD       (INTD),
        .vector     (vector),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          i;
        logic          n;
        logic          d;
        logic [IW-1:0] v;
        logic [N-1:0]  p;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_pass = 0;

    // Reference model: what the CPU sees, as plain flags.
    bit [N-1:0] m_pend, m_irq_prev, m_mask;
    bit         m_npend, m_nmi_prev;
    bit         m_int_req, m_in_svc, m_in_nmi, m_saved_svc;
    int         m_id;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endfunction

    function automatic void model_reset();
        m_pend = '0; m_irq_prev = '0; m_mask = '1;
        m_npend = 0; m_nmi_prev = 0;
        m_int_req = 0; m_in_svc = 0; m_in_nmi = 0; m_saved_svc = 0;
        m_id = 0;
    endfunction

    function automatic void model_edge();
        bit [N-1:0] rise;
        bit [N-1:0] nxt;
        bit         acked, take_nmi, nmi_rise;
        int         win;
        if (!rst_n) begin
            model_reset();
            return;
        end
        rise     = irq & ~m_irq_prev;
        nmi_rise = nmi_src && !m_nmi_prev;
        acked    = ack && ack_int && m_int_req;
        take_nmi = ack && !ack_int && m_npend && !m_in_nmi;
        nxt = m_pend | rise;
        if (acked) nxt[m_id] = rise[m_id];
        win = -1;
        for (int i = N - 1; i >= 0; i--)
            if (m_pend[i] && !m_mask[i]) win = i;

        if (take_nmi) begin
            m_saved_svc = m_in_svc;
            m_in_nmi = 1; m_in_svc = 0; m_int_req = 0;
        end else if (m_in_nmi) begin
            if (eoi) begin
                m_in_nmi = 0;
                m_in_svc = m_saved_svc;
            end
        end else if (m_in_svc) begin
            if (eoi) m_in_svc = 0;
        end else if (m_int_req) begin
            if (acked) begin
                m_int_req = 0; m_in_svc = 1;
            end else if (m_mask[m_id]) begin
                m_int_req = 0;
            end
        end else if (win >= 0) begin
            m_int_req = 1;
            m_id = win;
        end

        m_pend     = nxt;
        m_npend    = nmi_rise || (m_npend && !take_nmi);
        if (mask_we) m_mask = mask_wdata;
        m_irq_prev = irq;
        m_nmi_prev = nmi_src;
    endfunction

    function automatic exp_t snap();
        exp_t e;
        e.i = m_int_req;
        e.n = m_npend;
        e.d = m_in_svc || (m_in_nmi && m_saved_svc);
        e.v = IW'(m_id);
        e.p = m_pend;
        return e;
    endfunction

    // Monitor: compare the DUT against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("INT", 32'(INT), 32'(e.i));
            chk("NMI", 32'(NMI), 32'(e.n));
            chk("INTD", 32'(INTD), 32'(e.d));
            chk("vector", 32'(vector), 32'(e.v));
            chk("pending", 32'(pending), 32'(e.p));
        end
    end

    task automatic tick();
        @(posedge clk);
        model_edge();
        sb.push_back(snap());
        #1;
        ack = 1'b0; eoi = 1'b0; mask_we = 1'b0;
    endtask

    task automatic do_ack(input logic ai);
        ack = 1'b1; ack_int = ai; tick();
    endtask

    task automatic do_eoi();
        eoi = 1'b1; tick();
    endtask

    task automatic set_mask(input logic [N-1:0] m);
        mask_we = 1'b1; mask_wdata = m; tick();
    endtask

    task automatic mid_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_INT", 32'(INT), 0);
        chk("rst_NMI", 32'(NMI), 0);
        chk("rst_INTD", 32'(INTD), 0);
        chk("rst_vector", 32'(vector), 0);
        chk("rst_pending", 32'(pending), 0);
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (2) tick();
        rst_n = 1'b1;

        // Single request, full service round trip.
        set_mask('0);
        irq = 8'h08; tick();
        tick();
        chk("d1_INT", 32'(INT), 1);
        chk("d1_vec", 32'(vector), 3);
        irq = '0;
        do_ack(1'b1);
        chk("d1_INTD", 32'(INTD), 1);
        chk("d1_p3", 32'(pending[3]), 0);
        do_eoi();
        chk("d1_INTD_eoi", 32'(INTD), 0);

        // Simultaneous requests resolve lowest index first.
        irq = 8'h24; tick();
        irq = '0; tick();
        chk("d2_vec2", 32'(vector), 2);
        do_ack(1'b1);
        do_eoi();
        tick();
        chk("d2_INT5", 32'(INT), 1);
        chk("d2_vec5", 32'(vector), 5);
        do_ack(1'b1);
        do_eoi();

        // Masked request is held, then released by unmasking.
        set_mask(8'h10);
        irq = 8'h10; tick();
        irq = '0; tick(); tick();
        chk("d3_INT_masked", 32'(INT), 0);
        chk("d3_p4", 32'(pending[4]), 1);
        set_mask('0);
        tick();
        chk("d3_INT", 32'(INT), 1);
        chk("d3_vec4", 32'(vector), 4);
        do_ack(1'b1);
        do_eoi();

        // NMI preempts a maskable handler and returns to it.
        irq = 8'h02; tick();
        irq = '0; tick();
        do_ack(1'b1);
        nmi_src = 1'b1; tick();
        chk("d4_NMI", 32'(NMI), 1);
        nmi_src = 1'b0;
        do_ack(1'b0);
        chk("d4_NMI_taken", 32'(NMI), 0);
        chk("d4_INTD_nmi", 32'(INTD), 1);
        do_eoi();
        chk("d4_INTD_back", 32'(INTD), 1);
        do_eoi();
        chk("d4_INTD_done", 32'(INTD), 0);

        // Spurious acknowledges and eoi while idle.
        do_ack(1'b1);
        do_eoi();
        do_ack(1'b0);
        chk("d5_INT", 32'(INT), 0);
        chk("d5_INTD", 32'(INTD), 0);

        // Asynchronous reset while in service with two lines pending.
        irq = 8'h81; tick();
        irq = '0; tick();
        do_ack(1'b1);
        irq = 8'h01; tick();
        chk("d6_pend81", 32'(pending), 32'h81);
        mid_reset();
        tick(); tick(); tick();
        chk("d6_masked_INT", 32'(INT), 0);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 599) == 0) begin
                mid_reset();
            end else begin
                irq = irq ^ N'($urandom() & $urandom() & $urandom());
                if ($urandom_range(0, 11) == 0) nmi_src = ~nmi_src;
                if ($urandom_range(0, 15) == 0) begin
                    mask_we = 1'b1;
                    mask_wdata = N'($urandom() & $urandom());
                end
                if ($urandom_range(0, 3) == 0) begin
                    ack = 1'b1;
                    ack_int = ($urandom_range(0, 2) != 0);
                end
                if ($urandom_range(0, 5) == 0) eoi = 1'b1;
                tick();
            end
        end

        for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge clk);
        #2;
        chk("drain", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
